dma_chan_req_encoder_128x7: RTL

//  Reverse of the 7->128 one-hot channel decoder: collects up to 128 per-channel DMA request

---
 rtl/dma_chan_req_encoder_128x7_if.sv | 23 ++
 rtl/dma_chan_req_encoder_128x7.sv | 85 ++++++++
 2 files changed

// File: rtl/dma_chan_req_encoder_128x7_if.sv
// Request/grant bundle between channel request lines, the encoder and the DMA sequencer.
interface dma_chan_req_encoder_128x7_if #(
    parameter int NUM_CH = 128,
    parameter int IDX_W  = 7
);
    logic [NUM_CH-1:0] req_set;
    logic [NUM_CH-1:0] req_mask;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_ready;
    logic [NUM_CH-1:0] pending;
    logic              any_pending;

    modport master (
        output req_set, req_mask, grant_ready,
        input  grant_valid, grant_idx, pending, any_pending
    );

    modport slave (
        input  req_set, req_mask, grant_ready,
        output grant_valid, grant_idx, pending, any_pending
    );
endinterface

// File: rtl/dma_chan_req_encoder_128x7.sv
// Sticky per-channel request collector with a round-robin encoder that hands out one
// channel index per valid/ready handshake.
module dma_chan_req_encoder_128x7 #(
    parameter int NUM_CH = 128,
    parameter int IDX_W  = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    dma_chan_req_encoder_128x7_if.slave   bus
);
    logic [NUM_CH-1:0]   pending_q;
    logic [NUM_CH-1:0]   pending_d;
    logic                any_q;
    logic                grant_valid_q;
    logic [IDX_W-1:0]    grant_idx_q;
    logic [IDX_W-1:0]    rr_ptr;

    logic                accept;
    logic                load;
    logic [NUM_CH-1:0]   clr;
    logic [NUM_CH-1:0]   eligible;
    logic [IDX_W-1:0]    start;
    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    logic [IDX_W-1:0]    off;
    logic                cand_valid;
    logic [IDX_W-1:0]    cand_idx;

    assign accept = grant_valid_q & bus.grant_ready;
    assign load   = ~grant_valid_q | accept;

    always_comb begin
        clr = '0;
        if (accept) clr[grant_idx_q] = 1'b1;
    end

    // Set wins over clear so a re-request during its own accept is not lost.
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_pend
            assign pending_d[g] = (pending_q[g] & ~clr[g]) | bus.req_set[g];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) pending_q[g] <= 1'b0;
                else     pending_q[g] <= pending_d[g];
            end
        end
    endgenerate

    assign eligible = pending_q & bus.req_mask & ~clr;
    assign start    = accept ? grant_idx_q + 1'b1 : rr_ptr;

    // Rotate so the start index sits at bit 0, then take the lowest set bit.
    assign dbl = {eligible, eligible} >> start;
    assign rot = dbl[NUM_CH-1:0];

    always_comb begin
        off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        cand_valid = |rot;
        cand_idx   = start + off;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_q         <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            rr_ptr        <= '0;
        end else begin
            any_q <= |pending_d;
            if (accept) rr_ptr <= grant_idx_q + 1'b1;
            if (load) begin
                grant_valid_q <= cand_valid;
                if (cand_valid) grant_idx_q <= cand_idx;
            end
        end
    end

    assign bus.pending     = pending_q;
    assign bus.any_pending = any_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_idx   = grant_idx_q;
endmodule
